load_store_unit: RTL and testbench

- Parametrised, multi-cycle load/store unit with its own data memory. Supersedes the flat doubleword data-memory array used by the single-cycle datapath.
- Supports byte, half, word and double accesses with sign or zero extension.
- Uses valid/ready handshakes on request and response, and a configurable memory wait-state count.
- Detects misaligned, out-of-range and illegal-size accesses and reports them as errors instead of silently corrupting memory.
- Sits between the execute stage (address = ALU result) and write-back.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   size_e  : access size encodings (byte/half/word/double)
//   err_e   : response error codes
//   state_e : control FSM states
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_SIZE     = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus of the load/store unit.
//   master : execute stage side (drives requests, consumes responses)
//   slave  : load/store unit side
interface load_store_unit_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic [4:0]      resp_rd;
  logic [1:0]      resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_err,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit.
//   i_word     : current memory word
//   i_wdata    : store data (low bytes used)
//   i_size     : access size
//   i_offset   : byte offset inside the word
//   i_unsigned : zero-extend loads when set
//   o_load     : extracted and extended load data
//   o_merged   : memory word with the addressed bytes replaced by store data
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  input  size_e           i_size,
  input  logic [OFFW-1:0] i_offset,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_merged
);

  logic [OFFW+2:0] w_shamt;
  logic [XLEN-1:0] w_field_mask;
  logic [XLEN-1:0] w_sign_mask;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_lane_mask;
  logic            w_sign;

  always_comb begin
    w_shamt      = {i_offset, 3'b000};
    w_field_mask = '1;
    case (i_size)
      SZ_B:    w_field_mask = XLEN'(8'hFF);
      SZ_H:    w_field_mask = XLEN'(16'hFFFF);
      SZ_W:    w_field_mask = XLEN'(32'hFFFF_FFFF);
      default: w_field_mask = '1;
    endcase
    // Top bit of the field mask selects the sign bit; a full-width field
    // has no bits above it, so extension (and i_unsigned) has no effect.
    w_sign_mask = w_field_mask & ~(w_field_mask >> 1);
    w_shifted   = i_word >> w_shamt;
    w_sign      = ~i_unsigned & (|(w_shifted & w_sign_mask));
    o_load      = (w_shifted & w_field_mask) | (w_sign ? ~w_field_mask : '0);

    w_lane_mask = w_field_mask << w_shamt;
    o_merged    = (i_word & ~w_lane_mask) | ((i_wdata << w_shamt) & w_lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with private data memory.
//   clock : system clock
//   reset : asynchronous, active-high
//   lsu   : request/response bus (slave side)
// Requests are accepted in IDLE, legal accesses spend MEM_LATENCY cycles in
// WAIT (memory updated / read on the last one), and every access, legal or
// not, completes with a held response in RESP.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave lsu
);

  localparam int OFFW = $clog2(XLEN / 8);
  localparam int AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e          r_state;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic [4:0]      r_resp_rd;
  err_e            r_resp_err;

  logic            r_write;
  logic            r_unsigned;
  size_e           r_size;
  logic [OFFW-1:0] r_off;
  logic [AW-1:0]   r_widx;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_cnt;

  logic [XLEN-1:0] r_mem [MEM_DEPTH];

  size_e           w_req_size;
  logic [XLEN-1:0] w_align_mask;
  logic [XLEN-1:0] w_word_full;
  err_e            w_err;
  logic [XLEN-1:0] w_rd_word;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merged;
  logic            w_last_wait;
  logic            w_commit;

  // Acceptance-time checks, highest priority first.
  always_comb begin
    w_req_size   = size_e'(lsu.req_size);
    w_align_mask = (XLEN'(1) << lsu.req_size) - XLEN'(1);
    w_word_full  = lsu.req_addr >> OFFW;
    if (XLEN == 32 && w_req_size == SZ_D)
      w_err = ERR_SIZE;
    else if ((lsu.req_addr & w_align_mask) != '0)
      w_err = ERR_MISALIGN;
    else if (w_word_full >= XLEN'(MEM_DEPTH))
      w_err = ERR_RANGE;
    else
      w_err = ERR_NONE;
  end

  assign w_rd_word   = r_mem[r_widx];
  assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);
  // Gating with reset keeps a store from landing on an edge where reset is
  // already asserted.
  assign w_commit    = w_last_wait && r_write && !reset;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .i_word     (w_rd_word),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_offset   (r_off),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  // Memory is kept out of the reset domain so its contents survive reset.
  always_ff @(posedge clock) begin
    if (w_commit)
      r_mem[r_widx] <= w_merged;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_rd    <= '0;
      r_resp_err   <= ERR_NONE;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= SZ_B;
      r_off        <= '0;
      r_widx       <= '0;
      r_wdata      <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lsu.req_valid && r_req_ready) begin
            r_write     <= lsu.req_write;
            r_unsigned  <= lsu.req_unsigned;
            r_size      <= w_req_size;
            r_off       <= lsu.req_addr[OFFW-1:0];
            r_widx      <= w_word_full[AW-1:0];
            r_wdata     <= lsu.req_wdata;
            r_rd        <= lsu.req_rd;
            r_req_ready <= 1'b0;
            if (w_err != ERR_NONE) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_rd    <= lsu.req_rd;
              r_resp_err   <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CW'(MEM_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? '0 : w_load;
            r_resp_rd    <= r_rd;
            r_resp_err   <= ERR_NONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          if (lsu.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign lsu.req_ready  = r_req_ready;
  assign lsu.resp_valid = r_resp_valid;
  assign lsu.resp_rdata = r_resp_rdata;
  assign lsu.resp_rd    = r_resp_rd;
  assign lsu.resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=64, MEM_DEPTH=1024,
// MEM_LATENCY=2). A byte-array memory model predicts every response.
module tb_load_store_unit;

  localparam int XLEN  = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clock;
  logic reset;

  load_store_unit_if #(.XLEN(XLEN)) bus ();

  load_store_unit #(
    .XLEN        (XLEN),
    .MEM_DEPTH   (DEPTH),
    .MEM_LATENCY (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .lsu   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl [DEPTH*8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_err(input logic [1:0] sz, input logic [63:0] addr);
    int unsigned nb;
    nb = 1 << sz;
    if ((addr % nb) != 0) return 2'd1;
    if ((addr / 8) >= DEPTH) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [63:0] model_load(input logic [1:0] sz, input bit uns, input logic [63:0] addr);
    logic [63:0] v;
    int unsigned nb;
    nb = 1 << sz;
    v  = '0;
    for (int unsigned i = 0; i < nb; i++)
      v = v | (64'(mdl[addr + i]) << (8 * i));
    if (!uns && nb < 8 && v[8*nb-1])
      v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd);
    int unsigned nb;
    nb = 1 << sz;
    for (int unsigned i = 0; i < nb; i++)
      mdl[addr + i] = wd[8*i +: 8];
  endtask

  // Issues one request starting at a negedge; returns response fields and
  // the number of cycles from the accept cycle to resp_valid being seen.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [4:0] rd, input int hold,
                        output logic [63:0] rdata, output logic [1:0] err,
                        output logic [4:0] rtag, output int lat);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin
      @(posedge clock);
      #1 lat++;
    end
    if (lat >= 50) chk("resp_timeout", 64'(bus.resp_valid), 64'd1);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    rtag  = bus.resp_rd;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_rdata", bus.resp_rdata, rdata);
      chk("hold_rd",    64'(bus.resp_rd), 64'(rtag));
      chk("hold_err",   64'(bus.resp_err), 64'(err));
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clock);
    bus.resp_ready = 1'b1;
    @(posedge clock);
    #1 bus.resp_ready = 1'b0;
    chk("retire_valid", 64'(bus.resp_valid), 64'd0);
    chk("retire_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clock);
  endtask

  // Full access with model-predicted response, latency and tag.
  task automatic access(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd, input int hold);
    logic [63:0] rdata, exp_data;
    logic [1:0]  err, exp_err;
    logic [4:0]  rtag, rd;
    int          lat;
    rd       = 5'($urandom_range(0, 31));
    exp_err  = model_err(sz, addr);
    exp_data = (wr || exp_err != 2'd0) ? 64'd0 : model_load(sz, uns, addr);
    do_req(wr, sz, uns, addr, wd, rd, hold, rdata, err, rtag, lat);
    chk({tag, "_err"},   64'(err), 64'(exp_err));
    chk({tag, "_rdata"}, rdata, exp_data);
    chk({tag, "_rd"},    64'(rtag), 64'(rd));
    chk({tag, "_lat"},   64'(lat), (exp_err != 2'd0) ? 64'd1 : 64'(LAT + 1));
    if (wr && exp_err == 2'd0) model_store(sz, addr, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_rd       = '0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("rst_req_ready",  64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_rd",    64'(bus.resp_rd), 64'd0);
    chk("rst_resp_err",   64'(bus.resp_err), 64'd0);

    // Bring the region used below to a known state.
    for (int w = 0; w < 16; w++)
      access("init", 1'b1, 2'd3, 1'b0, 64'(w * 8), {$urandom, $urandom}, 0);

    // 1: double store/load round trip
    access("t1_st", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 0);
    access("t1_ld", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0);
    // 2: byte store, signed/unsigned/double loads
    access("t2_st",  1'b1, 2'd0, 1'b0, 64'h13, 64'h80, 0);
    access("t2_lbs", 1'b0, 2'd0, 1'b0, 64'h13, 64'd0, 0);
    access("t2_lbu", 1'b0, 2'd0, 1'b1, 64'h13, 64'd0, 0);
    access("t2_ld",  1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0);
    chk("t2_model", model_load(2'd3, 1'b0, 64'h10), 64'h1122334480667788);
    // 3: misaligned half load, memory unchanged
    access("t3_mis", 1'b0, 2'd1, 1'b0, 64'h11, 64'd0, 0);
    access("t3_ld",  1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0);
    // 4: out-of-range store, memory unchanged
    access("t4_rng", 1'b1, 2'd3, 1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    access("t4_ld",  1'b0, 2'd3, 1'b0, 64'h0, 64'd0, 0);
    access("t4_top", 1'b0, 2'd3, 1'b0, 64'h1FF8 + 64'h8, 64'd0, 0);

    // 5: reset while a store is in WAIT drops the store
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd1;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'h18;
    bus.req_wdata    = 64'hDEAD;
    bus.req_rd       = 5'd7;
    bus.req_valid    = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_req_ready",  64'(bus.req_ready), 64'd1);
    chk("t5_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clock);
    access("t5_ld", 1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 0);
    access("t5_lh", 1'b0, 2'd1, 1'b1, 64'h18, 64'd0, 0);

    // 6: backpressure on the response
    access("t6_ld", 1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 3);

    // Randomised mix of sizes, alignments, ranges and backpressure.
    for (int it = 0; it < 120; it++) begin
      logic [1:0]  sz;
      logic [63:0] addr;
      int unsigned kind;
      sz   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind == 0)
        addr = 64'h2000 + 64'($urandom_range(0, 255));
      else if (kind == 1)
        addr = {$urandom, $urandom};
      else
        addr = 64'($urandom_range(0, 127));
      if (kind >= 2 && kind < 8)
        addr = addr & ~((64'd1 << sz) - 64'd1);
      access("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             addr, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
